trapez_flattop_ctrl: RTL and testbench
======================================

TRAPEZ_FLATTOP_CTRL -- requirements
Module: trapez_flattop_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed shaper output sample width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of timing constants and counters.
REQ-003 SHALL have parameter PIPE_LAT, default 8, meaning shaper pipeline latency in clk cycles from window open to first valid output sample.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset_mult  input  1  reset, asynchronous, active-low; low closes the pulse window; its release opens it.
REQ-006 SHALL have port k_trapez  input  CNT_W  trapezoid rise length in cycles.
REQ-007 SHALL have port l_trapez  input  CNT_W  trapezoid k+flat length in cycles.
REQ-008 SHALL have port flat_skip  input  CNT_W  flat-top cycles ignored before averaging.
REQ-009 SHALL have port flat_len  input  CNT_W  number of flat-top samples accumulated.
REQ-010 SHALL have port avg_shift  input  5  arithmetic right shift applied to the sum.
REQ-011 SHALL have port shaper_data  input  DATA_W  signed shaper output.
REQ-012 SHALL have port energy  output  DATA_W  signed averaged flat-top value.
REQ-013 SHALL have port energy_valid  output  1  energy holds a result.
REQ-014 SHALL have port energy_ready  input  1  consumer accepts energy.
REQ-015 SHALL have port busy  output  1  measurement in progress (states DELAY, SKIP, ACCUM).
REQ-016 SHALL have port cfg_err  output  1  configuration invalid for this window.
REQ-017 SHALL have port sat  output  1  energy was clamped.

Function
REQ-018 Cycle index n: first rising clk edge after reset_mult release is n=1.
REQ-019 k_trapez, l_trapez, flat_skip, flat_len, avg_shift SHALL be latched at n=1; later changes ignored until next window.
REQ-020 Config invalid when l_trapez<=k_trapez, flat_len==0, or flat_skip+flat_len > l_trapez-k_trapez; then FSM goes DONE at n=1, cfg_err=1, energy_valid never asserted.
REQ-021 FSM states: DELAY -> SKIP -> ACCUM -> HOLD -> DONE; DONE exits only by reset.
REQ-022 DELAY: for edges n<=PIPE_LAT+k_trapez; SKIP: flat_skip edges (zero-length skip goes directly to ACCUM).
REQ-023 ACCUM: shaper_data sign-extended and added to a (DATA_W+CNT_W)-bit signed accumulator at edges n = PIPE_LAT+k+flat_skip+1 .. PIPE_LAT+k+flat_skip+flat_len; no wrap possible.
REQ-024 On the edge of the last accumulation, energy SHALL be loaded with (sum incl. last sample) >>> avg_shift, clamped to signed DATA_W range; sat=1 if clamped; energy_valid=1 from the next cycle (HOLD).
REQ-025 HOLD: energy and energy_valid stable until energy_ready=1 at a rising edge; then energy_valid=0 next cycle, state DONE, energy retains value.
REQ-026 energy_ready already high on entry to HOLD: transfer completes at first HOLD edge, energy_valid high exactly one cycle.
REQ-027 energy_ready outside HOLD SHALL be ignored.
REQ-028 One measurement per window; further flat-top samples ignored.
REQ-029 Counters SHALL be CNT_W+2 bits so PIPE_LAT+k+skip+len never wraps.

Reset
REQ-030 reset_mult low SHALL asynchronously clear: state=DELAY, counters, accumulator, energy=0, energy_valid=0, busy=0, cfg_err=0, sat=0.
REQ-031 busy SHALL be 1 from n=1 while in DELAY/SKIP/ACCUM; 0 during reset.
REQ-032 reset_mult low during any state, including HOLD, SHALL abort; result discarded, energy_valid drops immediately without handshake.

Verification
REQ-033 PIPE_LAT=8,k=4,l=10,skip=1,len=4,shift=2, shaper_data=100, ready=1 -> samples n=14..17, energy=100, energy_valid high only after edge n=17 for one cycle, sat=0.
REQ-034 Same, shaper_data=10,20,30,40 at n=14..17 (others 999) -> energy=25.
REQ-035 Same, ready=0 until n=25 -> energy_valid held n=17..25 edges, falls after n=25 edge, energy stable.
REQ-036 DATA_W=16, shaper_data=32767, len=4, shift=1 -> energy=32767, sat=1; data=-32768 -> energy=-32768, sat=1.
REQ-037 k=6,l=6 -> cfg_err=1 after n=1, busy=0, energy_valid stays 0; skip=5,len=2,k=4,l=10 -> cfg_err=1.
REQ-038 reset_mult low at n=15 then released -> outputs cleared at once; new window measures correctly with new k/l.

Source files
------------

// File: rtl/trapez_flattop_ctrl.sv
// rtl/trapez_flattop_ctrl.sv - flat-top averaging controller for a trapezoidal shaper window
module trapez_flattop_ctrl #(
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16,
    parameter int PIPE_LAT = 8
) (
    input  logic                     clk,
    input  logic                     reset_mult,
    input  logic [CNT_W-1:0]         k_trapez,
    input  logic [CNT_W-1:0]         l_trapez,
    input  logic [CNT_W-1:0]         flat_skip,
    input  logic [CNT_W-1:0]         flat_len,
    input  logic [4:0]               avg_shift,
    input  logic signed [DATA_W-1:0] shaper_data,
    output logic signed [DATA_W-1:0] energy,
    output logic                     energy_valid,
    input  logic                     energy_ready,
    output logic                     busy,
    output logic                     cfg_err,
    output logic                     sat
);
    localparam int NW = CNT_W + 2;
    localparam int AW = DATA_W + CNT_W;
    localparam logic signed [AW-1:0] E_MAX = {{(CNT_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] E_MIN = {{(CNT_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {DELAY, SKIP, ACCUM, HOLD, DONE} state_t;

    state_t                    state_q, state_d;
    logic [NW-1:0]             n_q, n_d;
    logic [CNT_W-1:0]          k_q, k_d, skip_q, skip_d, len_q, len_d;
    logic [4:0]                shift_q, shift_d;
    logic signed [AW-1:0]      acc_q, acc_d;
    logic signed [DATA_W-1:0]  energy_q, energy_d;
    logic                      energy_valid_q, energy_valid_d;
    logic                      busy_q, busy_d;
    logic                      cfg_err_q, cfg_err_d;
    logic                      sat_q, sat_d;

    logic                      first;
    logic [CNT_W-1:0]          k_e, skip_e, len_e;
    logic [4:0]                shift_e;
    logic [NW-1:0]             n_cur, t_delay, t_skip, t_acc;
    logic                      cfg_bad;
    logic signed [AW-1:0]      sample_ext, acc_sum, shifted;

    always_comb begin
        // Config is sampled on the first edge of the window, so that edge uses the live ports.
        first    = (state_q == DELAY) && (n_q == '0);
        k_e      = first ? k_trapez  : k_q;
        skip_e   = first ? flat_skip : skip_q;
        len_e    = first ? flat_len  : len_q;
        shift_e  = first ? avg_shift : shift_q;
        n_cur    = n_q + NW'(1);
        t_delay  = NW'(PIPE_LAT) + NW'(k_e);
        t_skip   = t_delay + NW'(skip_e);
        t_acc    = t_skip + NW'(len_e);
        cfg_bad  = (l_trapez <= k_trapez) || (flat_len == '0) ||
                   ((NW'(flat_skip) + NW'(flat_len)) > NW'(l_trapez - k_trapez));
        sample_ext = {{CNT_W{shaper_data[DATA_W-1]}}, shaper_data};
        acc_sum    = acc_q + sample_ext;
        shifted    = acc_sum >>> shift_e;

        state_d        = state_q;
        n_d            = n_q;
        k_d            = k_q;
        skip_d         = skip_q;
        len_d          = len_q;
        shift_d        = shift_q;
        acc_d          = acc_q;
        energy_d       = energy_q;
        energy_valid_d = energy_valid_q;
        busy_d         = busy_q;
        cfg_err_d      = cfg_err_q;
        sat_d          = sat_q;

        case (state_q)
            DELAY, SKIP, ACCUM: begin
                n_d = n_cur;
                if (first) begin
                    k_d     = k_trapez;
                    skip_d  = flat_skip;
                    len_d   = flat_len;
                    shift_d = avg_shift;
                end
                if (first && cfg_bad) begin
                    state_d   = DONE;
                    cfg_err_d = 1'b1;
                    busy_d    = 1'b0;
                end else if (n_cur > t_skip) begin
                    acc_d  = acc_sum;
                    busy_d = 1'b1;
                    if (n_cur == t_acc) begin
                        state_d        = HOLD;
                        busy_d         = 1'b0;
                        energy_valid_d = 1'b1;
                        if (shifted > E_MAX) begin
                            energy_d = {1'b0, {(DATA_W-1){1'b1}}};
                            sat_d    = 1'b1;
                        end else if (shifted < E_MIN) begin
                            energy_d = {1'b1, {(DATA_W-1){1'b0}}};
                            sat_d    = 1'b1;
                        end else begin
                            energy_d = shifted[DATA_W-1:0];
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    busy_d = 1'b1;
                    if (n_cur + NW'(1) <= t_delay)
                        state_d = DELAY;
                    else if (n_cur + NW'(1) <= t_skip)
                        state_d = SKIP;
                    else
                        state_d = ACCUM;
                end
            end
            HOLD: begin
                if (energy_ready) begin
                    energy_valid_d = 1'b0;
                    state_d        = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_mult) begin
        if (!reset_mult) begin
            state_q        <= DELAY;
            n_q            <= '0;
            k_q            <= '0;
            skip_q         <= '0;
            len_q          <= '0;
            shift_q        <= '0;
            acc_q          <= '0;
            energy_q       <= '0;
            energy_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            sat_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            k_q            <= k_d;
            skip_q         <= skip_d;
            len_q          <= len_d;
            shift_q        <= shift_d;
            acc_q          <= acc_d;
            energy_q       <= energy_d;
            energy_valid_q <= energy_valid_d;
            busy_q         <= busy_d;
            cfg_err_q      <= cfg_err_d;
            sat_q          <= sat_d;
        end
    end

    assign energy       = energy_q;
    assign energy_valid = energy_valid_q;
    assign busy         = busy_q;
    assign cfg_err      = cfg_err_q;
    assign sat          = sat_q;
endmodule

// File: tb/tb_trapez_flattop_ctrl.sv
// tb/tb_trapez_flattop_ctrl.sv - scoreboard bench for trapez_flattop_ctrl
module tb_trapez_flattop_ctrl;
    logic               clk = 1'b0;
    logic               reset_mult = 1'b0;
    logic [15:0]        k_trapez = '0, l_trapez = '0, flat_skip = '0, flat_len = '0;
    logic [4:0]         avg_shift = '0;
    logic signed [15:0] shaper_data = '0;
    logic signed [15:0] energy;
    logic               energy_valid, energy_ready = 1'b0, busy, cfg_err, sat;

    trapez_flattop_ctrl #(.DATA_W(16), .CNT_W(16), .PIPE_LAT(8)) dut (
        .clk(clk), .reset_mult(reset_mult), .k_trapez(k_trapez), .l_trapez(l_trapez),
        .flat_skip(flat_skip), .flat_len(flat_len), .avg_shift(avg_shift),
        .shaper_data(shaper_data), .energy(energy), .energy_valid(energy_valid),
        .energy_ready(energy_ready), .busy(busy), .cfg_err(cfg_err), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int energy;
        bit sat;
        int first;
        int last;
    } exp_t;

    exp_t sb[$];
    int tests_run = 0;
    int failed = 0;

    int samp[0:63];
    int ready_from;
    int obs_first, obs_last, obs_cnt;
    logic signed [15:0] obs_energy;
    logic obs_sat, stable_err, cfg_at1;
    logic busy_at[0:63];

    // Reference: sum samples on edges PIPE_LAT+k+skip+1 .. +len, shift, clamp to 16 bits.
    task automatic push_expect(input int k, input int skip, input int len, input int shift);
        exp_t e;
        longint sum;
        int ts;
        ts = 8 + k + skip;
        sum = 0;
        for (int n = ts + 1; n <= ts + len; n++) sum += samp[n];
        sum = sum >>> shift;
        e.sat = (sum > 32767) || (sum < -32768);
        e.energy = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : int'(sum);
        e.first = ts + len;
        e.last = (ready_from > e.first + 1) ? ready_from - 1 : e.first;
        sb.push_back(e);
    endtask

    task automatic run_window(input int k, input int l, input int skip, input int len,
                              input int shift, input int nedges);
        reset_mult = 1'b0;
        energy_ready = 1'b0;
        @(negedge clk);
        k_trapez = 16'(k); l_trapez = 16'(l); flat_skip = 16'(skip);
        flat_len = 16'(len); avg_shift = 5'(shift);
        reset_mult = 1'b1;
        obs_first = 0; obs_last = 0; obs_cnt = 0; stable_err = 1'b0;
        obs_energy = '0; obs_sat = 1'b0; cfg_at1 = 1'b0;
        for (int n = 1; n <= nedges; n++) begin
            shaper_data = 16'(samp[n]);
            energy_ready = (n >= ready_from);
            @(posedge clk);
            #1;
            if (n == 1) begin
                cfg_at1 = cfg_err;
                k_trapez = '0; l_trapez = '0; flat_skip = '0; flat_len = '0; avg_shift = 5'd31;
            end
            busy_at[n] = busy;
            if (energy_valid) begin
                if (obs_first == 0) begin
                    obs_first = n; obs_energy = energy; obs_sat = sat;
                end else if (energy !== obs_energy) begin
                    stable_err = 1'b1;
                end
                obs_last = n;
                obs_cnt++;
            end
        end
    endtask

    task automatic test_reset;
        reset_mult = 1'b0;
        #3;
        tests_run++;
        if ({energy, energy_valid, busy, cfg_err, sat} !== 20'd0) begin
            failed++;
            $display("FAIL reset_outputs: got %h want 0", {energy, energy_valid, busy, cfg_err, sat});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({energy_valid, busy} !== 2'b00) begin
            failed++;
            $display("FAIL reset_held: valid/busy %b want 00", {energy_valid, busy});
        end
    endtask

    task automatic test_const;
        exp_t e;
        for (int i = 0; i < 64; i++) samp[i] = 100;
        ready_from = 0;
        push_expect(4, 1, 4, 2);
        run_window(4, 10, 1, 4, 2, 22);
        e = sb.pop_front();
        tests_run++;
        if (int'(obs_energy) !== e.energy || obs_sat !== e.sat) begin
            failed++;
            $display("FAIL const_energy: got %0d sat %b want %0d sat %b", obs_energy, obs_sat, e.energy, e.sat);
        end
        tests_run++;
        if (obs_first !== e.first || obs_last !== e.last || obs_cnt !== 1) begin
            failed++;
            $display("FAIL const_valid_window: got %0d..%0d cnt %0d want %0d..%0d", obs_first, obs_last, obs_cnt, e.first, e.last);
        end
        tests_run++;
        if (busy_at[1] !== 1'b1 || busy_at[16] !== 1'b1 || busy_at[17] !== 1'b0 || cfg_at1 !== 1'b0) begin
            failed++;
            $display("FAIL const_busy: n1 %b n16 %b n17 %b cfg %b want 1 1 0 0", busy_at[1], busy_at[16], busy_at[17], cfg_at1);
        end
        tests_run++;
        if (energy !== obs_energy || energy_valid !== 1'b0) begin
            failed++;
            $display("FAIL const_retain: energy %0d valid %b want %0d 0", energy, energy_valid, obs_energy);
        end
    endtask

    task automatic test_ramp;
        exp_t e;
        for (int i = 0; i < 64; i++) samp[i] = 999;
        samp[14] = 10; samp[15] = 20; samp[16] = 30; samp[17] = 40;
        ready_from = 0;
        push_expect(4, 1, 4, 2);
        run_window(4, 10, 1, 4, 2, 22);
        e = sb.pop_front();
        tests_run++;
        if (int'(obs_energy) !== e.energy || obs_sat !== e.sat || obs_first !== e.first) begin
            failed++;
            $display("FAIL ramp_energy: got %0d sat %b at %0d want %0d sat %b at %0d", obs_energy, obs_sat, obs_first, e.energy, e.sat, e.first);
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        for (int i = 0; i < 64; i++) samp[i] = 100;
        ready_from = 25;
        push_expect(4, 1, 4, 2);
        run_window(4, 10, 1, 4, 2, 30);
        e = sb.pop_front();
        tests_run++;
        if (obs_first !== e.first || obs_last !== e.last || obs_cnt !== e.last - e.first + 1) begin
            failed++;
            $display("FAIL bp_valid_window: got %0d..%0d cnt %0d want %0d..%0d", obs_first, obs_last, obs_cnt, e.first, e.last);
        end
        tests_run++;
        if (stable_err !== 1'b0 || int'(energy) !== e.energy) begin
            failed++;
            $display("FAIL bp_stable: unstable %b final %0d want 0 %0d", stable_err, energy, e.energy);
        end
    endtask

    task automatic test_saturation;
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 64; i++) samp[i] = (pass == 0) ? 32767 : -32768;
            ready_from = 0;
            push_expect(4, 1, 4, 1);
            run_window(4, 10, 1, 4, 1, 20);
            e = sb.pop_front();
            tests_run++;
            if (int'(obs_energy) !== e.energy || obs_sat !== e.sat || sat !== 1'b1) begin
                failed++;
                $display("FAIL sat_pass%0d: got %0d sat %b want %0d sat %b", pass, obs_energy, obs_sat, e.energy, e.sat);
            end
        end
    endtask

    task automatic test_cfg_err;
        logic any_busy;
        for (int i = 0; i < 64; i++) samp[i] = 100;
        ready_from = 0;
        run_window(6, 6, 1, 4, 2, 20);
        any_busy = 1'b0;
        for (int n = 1; n <= 20; n++) any_busy |= busy_at[n];
        tests_run++;
        if (cfg_at1 !== 1'b1 || any_busy !== 1'b0 || obs_cnt !== 0) begin
            failed++;
            $display("FAIL cfg_k_eq_l: cfg %b busy %b valid_cnt %0d want 1 0 0", cfg_at1, any_busy, obs_cnt);
        end
        run_window(4, 10, 5, 2, 0, 20);
        tests_run++;
        if (cfg_at1 !== 1'b1 || obs_cnt !== 0) begin
            failed++;
            $display("FAIL cfg_overrun: cfg %b valid_cnt %0d want 1 0", cfg_at1, obs_cnt);
        end
        run_window(4, 10, 2, 4, 0, 3);
        tests_run++;
        if (cfg_at1 !== 1'b0 || busy_at[1] !== 1'b1) begin
            failed++;
            $display("FAIL cfg_exact_fit: cfg %b busy %b want 0 1", cfg_at1, busy_at[1]);
        end
    endtask

    task automatic test_abort;
        exp_t e;
        for (int i = 0; i < 64; i++) samp[i] = 100;
        ready_from = 0;
        run_window(4, 10, 1, 4, 2, 15);
        reset_mult = 1'b0;
        #1;
        tests_run++;
        if (busy_at[15] !== 1'b1 || {energy, energy_valid, busy, sat} !== 19'd0) begin
            failed++;
            $display("FAIL abort_accum: before busy %b after %h want 1 0", busy_at[15], {energy, energy_valid, busy, sat});
        end
        ready_from = 100;
        run_window(4, 10, 1, 4, 2, 20);
        reset_mult = 1'b0;
        #1;
        tests_run++;
        if (obs_cnt === 0 || energy_valid !== 1'b0 || energy !== 16'sd0) begin
            failed++;
            $display("FAIL abort_hold: held %0d valid %b energy %0d want >0 0 0", obs_cnt, energy_valid, energy);
        end
        for (int i = 0; i < 64; i++) samp[i] = i;
        ready_from = 0;
        push_expect(2, 2, 3, 0);
        run_window(2, 8, 2, 3, 0, 20);
        e = sb.pop_front();
        tests_run++;
        if (int'(obs_energy) !== e.energy || obs_first !== e.first || obs_last !== e.last) begin
            failed++;
            $display("FAIL abort_rewindow: got %0d at %0d..%0d want %0d at %0d..%0d", obs_energy, obs_first, obs_last, e.energy, e.first, e.last);
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_ramp();
        test_backpressure();
        test_saturation();
        test_cfg_err();
        test_abort();
        tests_run++;
        if (sb.size() !== 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
